clk_div_n_prog: RTL and testbench

//  Programmable integer clock divider (successor to the fixed divide-by-N block) with
//  50% duty for even and odd divisors.

---
 rtl/clk_div_n_prog.sv | 105 ++++++++++
 tb/tb_clk_div_n_prog.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_n_prog.sv
// Programmable integer clock divider: 50% duty for odd and even N, glitch-free divisor reload at period boundaries.
// Define CLK_DIV_TICK_EN to add the registered period-start pulse output `tick`.
module clk_div_n_prog #(
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_num,
    input  logic             div_load,
    output logic             div_busy,
`ifdef CLK_DIV_TICK_EN
    output logic             tick,
`endif
    output logic             clk_out
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_RESET);
    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

    if (DIV_RESET < 2 || DIV_RESET >= (1 << WIDTH)) begin : g_bad_div_reset
        $error("DIV_RESET out of range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             pos_hi_q, pos_hi_d;
    logic             neg_hi_q;
    logic             boundary;
    logic             start;
    logic [WIDTH-1:0] cnt_inc;

    // IDLE is treated as a boundary on every cycle so pending loads land immediately.
    always_comb begin
        boundary  = (state_q == S_IDLE) || (cnt_q == div_cur_q - WIDTH'(1));
        start     = boundary && en;
        cnt_inc   = cnt_q + WIDTH'(1);
        div_cur_d = (boundary && busy_q) ? pend_q : div_cur_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        if (boundary) busy_d = 1'b0;
        // A load on a boundary edge is kept pending for the next boundary.
        if (div_load) begin
            pend_d = (div_num < DIV_MIN) ? DIV_MIN : div_num;
            busy_d = 1'b1;
        end
        state_d  = S_RUN;
        cnt_d    = '0;
        pos_hi_d = 1'b0;
        if (start) begin
            pos_hi_d = 1'b1;
        end else if (boundary) begin
            state_d = S_IDLE;
        end else begin
            cnt_d    = cnt_inc;
            pos_hi_d = cnt_inc < (div_cur_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_cur_q <= DIV_RST;
            pend_q    <= '0;
            busy_q    <= 1'b0;
            pos_hi_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            pos_hi_q  <= pos_hi_d;
        end
    end

    // Half-cycle extension of the high phase, only for odd divisors.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) neg_hi_q <= 1'b0;
        else        neg_hi_q <= pos_hi_q & div_cur_q[0];
    end

`ifdef CLK_DIV_TICK_EN
    logic tick_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_q <= 1'b0;
        else        tick_q <= start;
    end
    assign tick = tick_q;
`endif

    assign clk_out  = pos_hi_q | neg_hi_q;
    assign div_busy = busy_q;

    a_cnt_range: assert property (@(posedge clk) disable iff (!reset) cnt_q < div_cur_q);
    a_div_min:   assert property (@(posedge clk) disable iff (!reset) div_cur_q >= DIV_MIN);

endmodule

// File: tb/tb_clk_div_n_prog.sv
// Directed, table-driven bench for clk_div_n_prog (tick checks compiled in with CLK_DIV_TICK_EN).
module tb_clk_div_n_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       ld = 1'b0;
    logic [6:0] num = '0;
    logic       busy;
    logic       clk_out;
    logic       tk = 1'b0;
`ifdef CLK_DIV_TICK_EN
    logic       tick;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    clk_div_n_prog dut (
        .clk      (clk),
        .reset    (rst_n),
        .en       (en),
        .div_num  (num),
        .div_load (ld),
        .div_busy (busy),
`ifdef CLK_DIV_TICK_EN
        .tick     (tick),
`endif
        .clk_out  (clk_out)
    );

    typedef struct {
        logic       en;
        logic       ld;
        logic [6:0] num;
        logic       a;     // clk_out in the high half of the input cycle
        logic       b;     // clk_out in the low half
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(logic e, logic l, logic [6:0] n, logic a, logic b, logic bz);
        vec_t r;
        r.en = e; r.ld = l; r.num = n; r.a = a; r.b = b; r.busy = bz;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    // One input cycle: inputs already driven are sampled at the posedge.
    task automatic cyc(output logic a, output logic b, output logic bz);
        @(posedge clk);
        #2;
        a  = clk_out;
        bz = busy;
`ifdef CLK_DIV_TICK_EN
        tk = tick;
`endif
        @(negedge clk);
        #2;
        b = clk_out;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, b, bz, prev_b;
        int   rises;

        // N=2 default, idle, then load 5 on a boundary
        v(0,0,0, 0,0,0); v(0,0,0, 0,0,0);
        v(1,0,0, 1,1,0); v(1,0,0, 0,0,0); v(1,0,0, 1,1,0); v(1,0,0, 0,0,0);
        v(1,1,5, 1,1,1); v(1,0,0, 0,0,1);
        // N=5: high 2.5 cycles
        v(1,0,0, 1,1,0); v(1,0,0, 1,1,0); v(1,0,0, 1,0,0); v(1,0,0, 0,0,0); v(1,0,0, 0,0,0);
        // two loads in one period (3 then 0): clamped 0 wins -> N=2
        v(1,0,0, 1,1,0); v(1,1,3, 1,1,1); v(1,1,0, 1,0,1); v(1,0,0, 0,0,1); v(1,0,0, 0,0,1);
        v(1,0,0, 1,1,0); v(1,0,0, 0,0,0);
        // load 1 -> clamped to 2
        v(1,1,1, 1,1,1); v(1,0,0, 0,0,1); v(1,0,0, 1,1,0); v(1,0,0, 0,0,0);
        // N=4, then load 7 during the first cycle of a period
        v(1,1,4, 1,1,1); v(1,0,0, 0,0,1); v(1,0,0, 1,1,0);
        v(1,1,7, 1,1,1); v(1,0,0, 0,0,1); v(1,0,0, 0,0,1);
        // N=7: high 3.5 cycles
        v(1,0,0, 1,1,0); v(1,0,0, 1,1,0); v(1,0,0, 1,1,0); v(1,0,0, 1,0,0);
        v(1,0,0, 0,0,0); v(1,0,0, 0,0,0); v(1,0,0, 0,0,0);
        // load 6 during a N=7 period
        v(1,0,0, 1,1,0); v(1,1,6, 1,1,1); v(1,0,0, 1,1,1); v(1,0,0, 1,0,1);
        v(1,0,0, 0,0,1); v(1,0,0, 0,0,1); v(1,0,0, 0,0,1);
        // N=6 with en dropped at cnt=2: period completes, then idle
        v(1,0,0, 1,1,0); v(1,0,0, 1,1,0); v(0,0,0, 1,1,0); v(0,0,0, 0,0,0);
        v(0,0,0, 0,0,0); v(0,0,0, 0,0,0); v(0,0,0, 0,0,0); v(0,0,0, 0,0,0); v(0,0,0, 0,0,0);
        // restart rises on the sampling edge
        v(1,0,0, 1,1,0); v(1,0,0, 1,1,0); v(1,0,0, 1,1,0); v(1,0,0, 0,0,0);

        #1;
        chk("reset.clk_out", clk_out, 0);
        chk("reset.busy", busy, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; ld = tbl[i].ld; num = tbl[i].num;
            cyc(a, b, bz);
            chk($sformatf("v%0d.hi_half", i), a, tbl[i].a);
            chk($sformatf("v%0d.lo_half", i), b, tbl[i].b);
            chk($sformatf("v%0d.busy", i), bz, tbl[i].busy);
        end

        // async reset while clk_out is high, with a load pending
        ld = 1'b1; num = 7'd9;
        cyc(a, b, bz);
        chk("ar.pre_busy", bz, 1);
        ld = 1'b0;
        cyc(a, b, bz);
        @(posedge clk);
        #2;
        chk("ar.high_before", clk_out, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar.clk_out_async", clk_out, 0);
        chk("ar.busy_async", busy, 0);
        en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(a, b, bz);
        chk("ar.idle", {a, b}, 2'b00);
        en = 1'b1;
        cyc(a, b, bz);
        chk("ar.div2_hi", {a, b}, 2'b11);
        cyc(a, b, bz);
        chk("ar.div2_lo", {a, b}, 2'b00);
        en = 1'b0;
        cyc(a, b, bz);
        chk("ar.stop", {a, b}, 2'b00);

        // load in IDLE applies at the next edge; then 10 periods of N=3
        ld = 1'b1; num = 7'd3;
        cyc(a, b, bz);
        chk("il.busy_set", bz, 1);
        chk("il.still_idle", a, 0);
        ld = 1'b0;
        rises  = 0;
        prev_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            en = (i <= 27);
            cyc(a, b, bz);
            if (i == 0) chk("il.busy_clear", bz, 0);
            if (a && !prev_b) rises++;
            prev_b = b;
            chk($sformatf("p3.%0d.hi_half", i), a, (i < 30) && (i % 3 != 2));
`ifdef CLK_DIV_TICK_EN
            chk($sformatf("p3.%0d.tick", i), tk, (i < 30) && (i % 3 == 0));
`endif
        end
        chk("p3.periods", rises, 10);
        chk("p3.final_low", clk_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
